// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the shared-multiplier arbiter
// Contents: product_width(), tag_t {valid,id}, rr_pick() wrap-around priority search.
package mult_pkg;
  localparam int REQ_MAX = 256;
  localparam int ID_MAX_W = 8;
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
  function automatic int product_width(input int a0_w, input int a1_w);
    return a0_w + a1_w;
  endfunction
  // First set bit of req[0..n-1] searching upward from ptr with wrap; -1 if none.
  function automatic int rr_pick(input logic [REQ_MAX-1:0] req, input int n, input int ptr);
    int pick;
    int idx;
    pick = -1;
    for (int i = 0; i < REQ_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (pick < 0 && i < n && idx < REQ_MAX && req[idx]) pick = idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one request starting at ptr
// Ports: req (requests), ptr (search start) -> gnt (one-hot/zero), gnt_id (winner index), any (a grant exists)
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);
  int pick;
  always_comb begin
    pick = rr_pick(REQ_MAX'(req), NUM_REQ, int'(ptr));
    any = pick >= 0;
    gnt_id = IDW'(pick);
    gnt = any ? NUM_REQ'(1) << gnt_id : '0;
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one pipelined multiplier among NUM_REQ requesters
// Ports: clk, rst (async, active-high); req/a0_bus/a1_bus from clients, gnt back (combinational);
//   mul_valid/mul_a0/mul_a1 to the multiplier, mul_product from it; rsp_valid/rsp_product to clients.
// Option MULT_PERF_EN: adds saturating gnt_count/stall_count outputs.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int a0_width     = 8,
  parameter int a1_width     = 8,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [NUM_REQ*a0_width-1:0]                 a0_bus,
  input  logic [NUM_REQ*a1_width-1:0]                 a1_bus,
  output logic [NUM_REQ-1:0]                          gnt,
  output logic                                        mul_valid,
  output logic [a0_width-1:0]                         mul_a0,
  output logic [a1_width-1:0]                         mul_a1,
  input  logic [product_width(a0_width,a1_width)-1:0] mul_product,
  output logic [NUM_REQ-1:0]                          rsp_valid,
  output logic [product_width(a0_width,a1_width)-1:0] rsp_product
`ifdef MULT_PERF_EN
  ,
  output logic [15:0]                                 gnt_count,
  output logic [15:0]                                 stall_count
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [IDW-1:0]              ptr;
  logic [IDW-1:0]              ptr_nxt;
  logic [IDW-1:0]              gnt_id;
  logic [NUM_REQ-1:0]          arb_gnt;
  logic                        any;
  tag_t [MULT_LATENCY-1:0]     pipe;
  tag_t                        last;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );
  always_comb begin
    gnt = rst ? '0 : arb_gnt;
    ptr_nxt = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    last = pipe[MULT_LATENCY-1];
  end
  // The tag pipe mirrors the multiplier's latency so each product is matched to its requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      mul_valid   <= 1'b0;
      mul_a0      <= '0;
      mul_a1      <= '0;
      pipe        <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
    end else begin
      ptr       <= any ? ptr_nxt : ptr;
      mul_valid <= any;
      if (any) begin
        mul_a0 <= a0_bus[gnt_id*a0_width +: a0_width];
        mul_a1 <= a1_bus[gnt_id*a1_width +: a1_width];
      end
      pipe[0] <= '{valid: any, id: ID_MAX_W'(gnt_id)};
      for (int s = 1; s < MULT_LATENCY; s++) pipe[s] <= pipe[s-1];
      rsp_valid <= last.valid ? NUM_REQ'(1) << IDW'(last.id) : '0;
      if (last.valid) rsp_product <= mul_product;
    end
  end
`ifdef MULT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (any && gnt_count != 16'hFFFF) gnt_count <= gnt_count + 16'd1;
      if (|(req & ~gnt) && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a0_bus;
  logic [31:0] a1_bus;
  logic [3:0]  gnt;
  logic        mul_valid;
  logic [7:0]  mul_a0;
  logic [7:0]  mul_a1;
  logic [15:0] mul_product;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_product;
`ifdef MULT_PERF_EN
  logic [15:0] gnt_count;
  logic [15:0] stall_count;
`endif
  int checks = 0;
  int errors = 0;
  mult_share_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .a0_bus      (a0_bus),
    .a1_bus      (a1_bus),
    .gnt         (gnt),
    .mul_valid   (mul_valid),
    .mul_a0      (mul_a0),
    .mul_a1      (mul_a1),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product)
`ifdef MULT_PERF_EN
    ,
    .gnt_count   (gnt_count),
    .stall_count (stall_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Two-cycle multiplier: operands registered by the DUT at edge E0 give a product usable during the following cycle.
  always @(posedge clk) mul_product <= mul_a0 * mul_a1;
  task automatic set_ops(input int i, input logic [7:0] x, input logic [7:0] y);
    a0_bus[i*8 +: 8] = x;
    a1_bus[i*8 +: 8] = y;
  endtask
  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    set_ops(0, 8'd5, 8'd6);
    set_ops(1, 8'd7, 8'd8);
    set_ops(2, 8'd9, 8'd10);
    set_ops(3, 8'd11, 8'd12);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if ({mul_valid, mul_a0, mul_a1, rsp_valid, rsp_product} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mv=%b a0=%0d a1=%0d rv=%b rp=%0d exp=all 0", mul_valid, mul_a0, mul_a1, rsp_valid, rsp_product);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL ptr_after_first got=%b exp=0010", gnt); end
    checks++;
    if (mul_valid !== 1'b1 || mul_a0 !== 8'd5 || mul_a1 !== 8'd6) begin
      errors++;
      $display("FAIL first_issue got mv=%b a0=%0d a1=%0d exp mv=1 a0=5 a1=6", mul_valid, mul_a0, mul_a1);
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_single();
    do_reset();
    set_ops(2, 8'd200, 8'd3);
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    @(negedge clk);
    req = '0;
    checks++;
    if (mul_valid !== 1'b1 || mul_a0 !== 8'd200 || mul_a1 !== 8'd3) begin
      errors++;
      $display("FAIL single_issue got mv=%b a0=%0d a1=%0d exp mv=1 a0=200 a1=3", mul_valid, mul_a0, mul_a1);
    end
    @(negedge clk);
    checks++;
    if (mul_valid !== 1'b0 || mul_a0 !== 8'd200 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_hold got mv=%b a0=%0d rv=%b exp mv=0 a0=200 rv=0000", mul_valid, mul_a0, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_product !== 16'd600) begin
      errors++;
      $display("FAIL single_rsp got rv=%b rp=%0d exp rv=0100 rp=600", rsp_valid, rsp_product);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_product !== 16'd600) begin
      errors++;
      $display("FAIL single_rsp_drop got rv=%b rp=%0d exp rv=0000 rp=600", rsp_valid, rsp_product);
    end
  endtask
  task automatic test_round_robin();
    logic [15:0] prod [4];
    logic [3:0]  eg;
    logic [3:0]  er;
    prod[0] = 16'd65025;
    prod[1] = 16'd408;
    prod[2] = 16'd10000;
    prod[3] = 16'd323;
    do_reset();
    set_ops(0, 8'd255, 8'd255);
    set_ops(1, 8'd12, 8'd34);
    set_ops(2, 8'd100, 8'd100);
    set_ops(3, 8'd17, 8'd19);
    req = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      if (c == 8) req = '0;
      #1;
      eg = (c < 8) ? 4'b0001 << (c % 4) : 4'b0000;
      er = (c >= 3) ? 4'b0001 << ((c - 3) % 4) : 4'b0000;
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, gnt, eg); end
      checks++;
      if (rsp_valid !== er) begin errors++; $display("FAIL rr_rsp_valid cycle=%0d got=%b exp=%b", c, rsp_valid, er); end
      if (c >= 3) begin
        checks++;
        if (rsp_product !== prod[(c - 3) % 4]) begin
          errors++;
          $display("FAIL rr_rsp_product cycle=%0d got=%0d exp=%0d", c, rsp_product, prod[(c - 3) % 4]);
        end
      end
      @(negedge clk);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_setup got=%b exp=0100", gnt); end
    @(negedge clk);
    req = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_ptr3 got=%b exp=1000", gnt); end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_to0 got=%b exp=0001", gnt); end
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset_inflight();
    do_reset();
    set_ops(0, 8'd3, 8'd4);
    set_ops(1, 8'd5, 8'd6);
    set_ops(3, 8'd9, 8'd9);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (mul_valid !== 1'b0 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL inflight_async got mv=%b rv=%b exp mv=0 rv=0000", mul_valid, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL inflight_discard cycle=%0d got=%b exp=0000", c, rsp_valid); end
    end
    req = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL after_rst_gnt got=%b exp=1000", gnt); end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_product !== 16'd81) begin
      errors++;
      $display("FAIL after_rst_rsp got rv=%b rp=%0d exp rv=1000 rp=81", rsp_valid, rsp_product);
    end
  endtask
`ifdef MULT_PERF_EN
  task automatic test_perf();
    do_reset();
    req = 4'b0011;
    repeat (10) @(negedge clk);
    req = '0;
    #1;
    checks++;
    if (gnt_count !== 16'd10 || stall_count !== 16'd10) begin
      errors++;
      $display("FAIL perf_count got g=%0d s=%0d exp g=10 s=10", gnt_count, stall_count);
    end
    do_reset();
    req = 4'b0011;
    repeat (65540) @(negedge clk);
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt_count !== 16'hFFFF || stall_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL perf_saturate got g=%h s=%h exp g=ffff s=ffff", gnt_count, stall_count);
    end
  endtask
`endif
  initial begin
    req = '0;
    a0_bus = '0;
    a1_bus = '0;
    rst = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_inflight();
`ifdef MULT_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
